// File: rtl/muxtree_pkg.sv
// Shared types and defaults for the muxtree selection pipeline.
package muxtree_pkg;

  typedef enum logic [2:0] {
    SRC_E     = 3'd0,
    SRC_C     = 3'd1,
    SRC_D     = 3'd2,
    SRC_FORCE = 3'd3,
    SRC_HOLD  = 3'd4
  } muxtree_src_t;

  localparam int unsigned SRC_W         = 3;
  localparam int unsigned FORCE_VAL_DEF = 42;

endpackage

// File: rtl/muxtree_sel_pipe_if.sv
// Input beat and result beat channels of the muxtree selection pipeline.
interface muxtree_sel_pipe_if
  import muxtree_pkg::*;
#(
  parameter int unsigned N = 8,
  parameter int unsigned C = 4
);
  localparam int unsigned SW = $clog2(C);

  logic                IN_valid;
  logic                IN_ready;
  logic                IN_force;
  logic [SW-1:0]       IN_sel;
  logic [C-1:0]        IN_b;
  logic [C-1:0]        IN_b2;
  logic [C-1:0][N-1:0] IN_valC;
  logic [C-1:0][N-1:0] IN_valD;
  logic [C-1:0][N-1:0] IN_valE;

  logic                OUT_valid;
  logic                OUT_ready;
  logic [N-1:0]        OUT_val;
  muxtree_src_t        OUT_src;
  logic                OUT_miss;

  modport master (
    output IN_valid, IN_force, IN_sel, IN_b, IN_b2, IN_valC, IN_valD, IN_valE,
    input  IN_ready,
    input  OUT_valid, OUT_val, OUT_src, OUT_miss,
    output OUT_ready
  );

  modport slave (
    input  IN_valid, IN_force, IN_sel, IN_b, IN_b2, IN_valC, IN_valD, IN_valE,
    output IN_ready,
    output OUT_valid, OUT_val, OUT_src, OUT_miss,
    input  OUT_ready
  );

endinterface

// File: rtl/muxtree_prio_lane.sv
// One channel's priority pick between the E, C and D candidates.
module muxtree_prio_lane
  import muxtree_pkg::*;
#(
  parameter int unsigned N = 8
) (
  input  logic         b,
  input  logic         b2,
  input  logic [N-1:0] val_c,
  input  logic [N-1:0] val_d,
  input  logic [N-1:0] val_e,
  output logic [N-1:0] lane_c,
  output muxtree_src_t src_c
);

  always_comb begin
    lane_c = val_d;
    src_c  = SRC_D;
    if (b && b2) begin
      lane_c = val_e;
      src_c  = SRC_E;
    end else if (b) begin
      lane_c = val_c;
      src_c  = SRC_C;
    end
  end

endmodule

// File: rtl/muxtree_sel_pipe.sv
// Two-stage channel selector: S1 captures all lane picks, S2 one-hot selects
// one of them, or the force value, or the last delivered value on a miss.
module muxtree_sel_pipe
  import muxtree_pkg::*;
#(
  parameter int unsigned N         = 8,
  parameter int unsigned C         = 4,
  parameter int unsigned FORCE_VAL = FORCE_VAL_DEF
) (
  input logic               clk,
  input logic               rst,
  muxtree_sel_pipe_if.slave bus
);

  localparam int unsigned SW = $clog2(C);
  localparam logic [N-1:0] FORCE_N = N'(FORCE_VAL);

  logic [C-1:0][N-1:0] lane_c;
  muxtree_src_t        lane_src_c [C];

  logic                s1_valid;
  logic [C-1:0][N-1:0] s1_lane;
  muxtree_src_t        s1_src [C];
  logic [SW-1:0]       s1_sel;
  logic                s1_force;

  logic [N-1:0]        hold;

  logic                s2_adv_c;
  logic                out_hs_c;
  logic [C-1:0]        onehot_c;
  logic [N-1:0]        sel_val_c;
  logic [SRC_W-1:0]    sel_src_c;
  logic                miss_c;
  logic [N-1:0]        hold_byp_c;
  logic [N-1:0]        nxt_val_c;
  muxtree_src_t        nxt_src_c;

  for (genvar k = 0; k < C; k++) begin : g_lane
    muxtree_prio_lane #(.N(N)) u_lane (
      .b      (bus.IN_b[k]),
      .b2     (bus.IN_b2[k]),
      .val_c  (bus.IN_valC[k]),
      .val_d  (bus.IN_valD[k]),
      .val_e  (bus.IN_valE[k]),
      .lane_c (lane_c[k]),
      .src_c  (lane_src_c[k])
    );
  end

  assign s2_adv_c     = !bus.OUT_valid || bus.OUT_ready;
  assign out_hs_c     = bus.OUT_valid && bus.OUT_ready;
  assign bus.IN_ready = !s1_valid || s2_adv_c;

  // S1: capture every lane so S2 only has to pick one.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
    end else if (bus.IN_ready) begin
      s1_valid <= bus.IN_valid;
      if (bus.IN_valid) begin
        s1_lane  <= lane_c;
        s1_src   <= lane_src_c;
        s1_sel   <= bus.IN_sel;
        s1_force <= bus.IN_force;
      end
    end
  end

  // AND-OR select; the hold value bypasses a same-cycle handoff.
  always_comb begin
    onehot_c  = '0;
    sel_val_c = '0;
    sel_src_c = '0;
    for (int unsigned k = 0; k < C; k++) begin
      onehot_c[k] = (s1_sel == SW'(k));
      sel_val_c   = sel_val_c | (s1_lane[k] & {N{onehot_c[k]}});
      sel_src_c   = sel_src_c | (SRC_W'(s1_src[k]) & {SRC_W{onehot_c[k]}});
    end
    miss_c     = !s1_force && ({1'b0, s1_sel} >= (SW + 1)'(C));
    hold_byp_c = (out_hs_c && !bus.OUT_miss) ? bus.OUT_val : hold;
    nxt_val_c  = sel_val_c;
    nxt_src_c  = muxtree_src_t'(sel_src_c);
    if (s1_force) begin
      nxt_val_c = FORCE_N;
      nxt_src_c = SRC_FORCE;
    end else if (miss_c) begin
      nxt_val_c = hold_byp_c;
      nxt_src_c = SRC_HOLD;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bus.OUT_valid <= 1'b0;
      bus.OUT_val   <= '0;
      bus.OUT_src   <= SRC_D;
      bus.OUT_miss  <= 1'b0;
    end else if (s2_adv_c) begin
      bus.OUT_valid <= s1_valid;
      if (s1_valid) begin
        bus.OUT_val  <= nxt_val_c;
        bus.OUT_src  <= nxt_src_c;
        bus.OUT_miss <= miss_c;
      end
    end
  end

  // Last value delivered without a miss, forced beats included.
  always_ff @(posedge clk) begin
    if (rst) begin
      hold <= FORCE_N;
    end else if (out_hs_c && !bus.OUT_miss) begin
      hold <= bus.OUT_val;
    end
  end

endmodule

// File: tb/tb_muxtree_sel_pipe.sv
// Bench for muxtree_sel_pipe: a C=4 and a C=3 instance against a beat-level model.
module tb_muxtree_sel_pipe;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  muxtree_sel_pipe_if #(.N(8), .C(4)) bus_a ();
  muxtree_sel_pipe_if #(.N(8), .C(3)) bus_b ();

  muxtree_sel_pipe #(.N(8), .C(4), .FORCE_VAL(42)) u_dut_a (.clk(clk), .rst(rst), .bus(bus_a));
  muxtree_sel_pipe #(.N(8), .C(3), .FORCE_VAL(42)) u_dut_b (.clk(clk), .rst(rst), .bus(bus_b));

  typedef struct {
    logic [7:0] val;
    logic [2:0] src;
    logic       miss;
    int         acc;
  } exp_t;

  exp_t       qa[$];
  exp_t       qb[$];
  exp_t       ea;
  exp_t       eb;
  logic [7:0] good_a = 8'd42;
  logic [7:0] good_b = 8'd42;
  int         cyc = 0;
  int         checks = 0;
  int         errors = 0;
  int         del_a = 0;
  bit         stall_a = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  // A beat's result: force, else the lane rule, else the last non-miss result.
  function automatic exp_t model(input logic f, input int unsigned sel, input int unsigned c,
                                 input logic [3:0] b, input logic [3:0] b2,
                                 input logic [3:0][7:0] vc, input logic [3:0][7:0] vd,
                                 input logic [3:0][7:0] ve, input logic [7:0] hold_v);
    exp_t e;
    e.acc  = 0;
    e.miss = 1'b0;
    if (f) begin
      e.val = 8'd42; e.src = 3'd3;
    end else if (sel < c) begin
      if (b[sel] && b2[sel]) begin e.val = ve[sel]; e.src = 3'd0; end
      else if (b[sel])       begin e.val = vc[sel]; e.src = 3'd1; end
      else                   begin e.val = vd[sel]; e.src = 3'd2; end
    end else begin
      e.val = hold_v; e.src = 3'd4; e.miss = 1'b1;
    end
    return e;
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (rst) begin
      qa.delete(); qb.delete();
      good_a = 8'd42; good_b = 8'd42;
    end else begin
      chk("a_in_ready", 32'(bus_a.IN_ready), 32'(!(qa.size() >= 2 && !bus_a.OUT_ready)));
      chk("a_out_valid", 32'(bus_a.OUT_valid), 32'(qa.size() > 0 && qa[0].acc + 2 <= cyc));
      if (bus_a.OUT_valid && qa.size() > 0) begin
        chk("a_val", 32'(bus_a.OUT_val), 32'(qa[0].val));
        chk("a_src", 32'(bus_a.OUT_src), 32'(qa[0].src));
        chk("a_miss", 32'(bus_a.OUT_miss), 32'(qa[0].miss));
        if (bus_a.OUT_ready) begin void'(qa.pop_front()); del_a++; end
      end
      if (bus_a.IN_valid && !bus_a.IN_ready) stall_a = 1'b1;
      if (bus_a.IN_valid && bus_a.IN_ready) begin
        ea = model(bus_a.IN_force, {30'd0, bus_a.IN_sel}, 4, bus_a.IN_b, bus_a.IN_b2,
                   bus_a.IN_valC, bus_a.IN_valD, bus_a.IN_valE, good_a);
        ea.acc = cyc;
        if (!ea.miss) good_a = ea.val;
        qa.push_back(ea);
      end

      chk("b_in_ready", 32'(bus_b.IN_ready), 32'(!(qb.size() >= 2 && !bus_b.OUT_ready)));
      chk("b_out_valid", 32'(bus_b.OUT_valid), 32'(qb.size() > 0 && qb[0].acc + 2 <= cyc));
      if (bus_b.OUT_valid && qb.size() > 0) begin
        chk("b_val", 32'(bus_b.OUT_val), 32'(qb[0].val));
        chk("b_src", 32'(bus_b.OUT_src), 32'(qb[0].src));
        chk("b_miss", 32'(bus_b.OUT_miss), 32'(qb[0].miss));
        if (bus_b.OUT_ready) void'(qb.pop_front());
      end
      if (bus_b.IN_valid && bus_b.IN_ready) begin
        eb = model(bus_b.IN_force, {30'd0, bus_b.IN_sel}, 3, {1'b0, bus_b.IN_b},
                   {1'b0, bus_b.IN_b2}, {8'h00, bus_b.IN_valC}, {8'h00, bus_b.IN_valD},
                   {8'h00, bus_b.IN_valE}, good_b);
        eb.acc = cyc;
        if (!eb.miss) good_b = eb.val;
        qb.push_back(eb);
      end
    end
  end

  // Present one beat (called just after a rising edge) and hold it until accepted.
  task automatic beat(input bit to_b, input logic f, input logic [1:0] sel,
                      input logic [3:0] b, input logic [3:0] b2,
                      input logic [31:0] vc, input logic [31:0] vd, input logic [31:0] ve);
    bit ok;
    ok = 1'b0;
    if (!to_b) begin
      bus_a.IN_valid = 1'b1; bus_a.IN_force = f; bus_a.IN_sel = sel;
      bus_a.IN_b = b; bus_a.IN_b2 = b2;
      bus_a.IN_valC = vc; bus_a.IN_valD = vd; bus_a.IN_valE = ve;
    end else begin
      bus_b.IN_valid = 1'b1; bus_b.IN_force = f; bus_b.IN_sel = sel;
      bus_b.IN_b = b[2:0]; bus_b.IN_b2 = b2[2:0];
      bus_b.IN_valC = vc[23:0]; bus_b.IN_valD = vd[23:0]; bus_b.IN_valE = ve[23:0];
    end
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge clk);
      ok = to_b ? bus_b.IN_ready : bus_a.IN_ready;
      @(posedge clk); #1;
    end
    chk("beat_accepted", 32'(ok), 32'd1);
    bus_a.IN_valid = 1'b0;
    bus_b.IN_valid = 1'b0;
  endtask

  task automatic wait_out(input bit to_b, input logic [7:0] val, input logic [2:0] src,
                          input logic miss, input string name);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 8 && !seen; i++) begin
      @(negedge clk);
      if (to_b ? bus_b.OUT_valid : bus_a.OUT_valid) begin
        seen = 1'b1;
        chk({name, "_val"}, 32'(to_b ? bus_b.OUT_val : bus_a.OUT_val), 32'(val));
        chk({name, "_src"}, 32'(to_b ? bus_b.OUT_src : bus_a.OUT_src), 32'(src));
        chk({name, "_miss"}, 32'(to_b ? bus_b.OUT_miss : bus_a.OUT_miss), 32'(miss));
      end
    end
    chk({name, "_seen"}, 32'(seen), 32'd1);
    @(posedge clk); #1;
  endtask

  task automatic rand_drive();
    bus_a.IN_valid  = ($urandom_range(0, 9) < 7);
    bus_a.IN_force  = ($urandom_range(0, 7) == 0);
    bus_a.IN_sel    = 2'($urandom_range(0, 3));
    bus_a.IN_b      = 4'($urandom);
    bus_a.IN_b2     = 4'($urandom);
    bus_a.IN_valC   = $urandom;
    bus_a.IN_valD   = $urandom;
    bus_a.IN_valE   = $urandom;
    bus_a.OUT_ready = ($urandom_range(0, 3) != 0);
    bus_b.IN_valid  = ($urandom_range(0, 9) < 7);
    bus_b.IN_force  = ($urandom_range(0, 7) == 0);
    bus_b.IN_sel    = 2'($urandom_range(0, 3));
    bus_b.IN_b      = 3'($urandom);
    bus_b.IN_b2     = 3'($urandom);
    bus_b.IN_valC   = 24'($urandom);
    bus_b.IN_valD   = 24'($urandom);
    bus_b.IN_valE   = 24'($urandom);
    bus_b.OUT_ready = ($urandom_range(0, 3) != 0);
  endtask

  logic [31:0] vd;
  logic [31:0] ve;
  int          d0;

  initial begin
    bus_a.IN_valid = 1'b0; bus_a.IN_force = 1'b0; bus_a.IN_sel = '0;
    bus_a.IN_b = '0; bus_a.IN_b2 = '0;
    bus_a.IN_valC = '0; bus_a.IN_valD = '0; bus_a.IN_valE = '0;
    bus_a.OUT_ready = 1'b1;
    bus_b.IN_valid = 1'b0; bus_b.IN_force = 1'b0; bus_b.IN_sel = '0;
    bus_b.IN_b = '0; bus_b.IN_b2 = '0;
    bus_b.IN_valC = '0; bus_b.IN_valD = '0; bus_b.IN_valE = '0;
    bus_b.OUT_ready = 1'b1;

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_out_valid", 32'(bus_a.OUT_valid), 32'd0);
    chk("rst_out_val", 32'(bus_a.OUT_val), 32'd0);
    chk("rst_out_src", 32'(bus_a.OUT_src), 32'd2);
    chk("rst_out_miss", 32'(bus_a.OUT_miss), 32'd0);
    chk("rst_in_ready", 32'(bus_a.IN_ready), 32'd1);
    chk("rst_b_out_valid", 32'(bus_b.OUT_valid), 32'd0);
    @(posedge clk); #1;

    // lane E pick on channel 2
    ve = $urandom; ve[23:16] = 8'h5A;
    beat(0, 1'b0, 2'd2, 4'b0100, 4'b0100, $urandom, $urandom, ve);
    wait_out(0, 8'h5A, 3'd0, 1'b0, "sel2_laneE");

    // force, then lane D on channel 1
    beat(0, 1'b1, 2'd1, 4'b0000, 4'($urandom), $urandom, $urandom, $urandom);
    wait_out(0, 8'd42, 3'd3, 1'b0, "force");
    vd = $urandom; vd[15:8] = 8'd7;
    beat(0, 1'b0, 2'd1, 4'b0000, 4'($urandom), $urandom, vd, $urandom);
    wait_out(0, 8'd7, 3'd2, 1'b0, "sel1_laneD");

    // C=3: a miss right behind a good beat picks up the handed-off value
    vd = $urandom; vd[15:8] = 8'h11;
    beat(1, 1'b0, 2'd1, 4'b0000, 4'($urandom), $urandom, vd, $urandom);
    beat(1, 1'b0, 2'd3, 4'($urandom), 4'($urandom), $urandom, $urandom, $urandom);
    wait_out(1, 8'h11, 3'd2, 1'b0, "c3_sel1");
    wait_out(1, 8'h11, 3'd4, 1'b1, "c3_miss_bypass");
    rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    beat(1, 1'b0, 2'd3, 4'($urandom), 4'($urandom), $urandom, $urandom, $urandom);
    wait_out(1, 8'd42, 3'd4, 1'b1, "c3_miss_after_rst");

    // 8 back-to-back beats with the output stalled for three cycles
    d0 = del_a;
    stall_a = 1'b0;
    fork
      begin
        for (int i = 0; i < 8; i++)
          beat(0, 1'b0, 2'($urandom_range(0, 3)), 4'($urandom), 4'($urandom),
               $urandom, $urandom, $urandom);
      end
      begin
        repeat (3) @(posedge clk);
        #1 bus_a.OUT_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1 bus_a.OUT_ready = 1'b1;
      end
    join
    repeat (6) @(posedge clk);
    #1;
    chk("b2b_delivered", 32'(del_a - d0), 32'd8);
    chk("b2b_in_ready_low", 32'(stall_a), 32'd1);

    // reset with two beats in flight
    beat(0, 1'b0, 2'd0, 4'($urandom), 4'($urandom), $urandom, $urandom, $urandom);
    beat(0, 1'b0, 2'd3, 4'($urandom), 4'($urandom), $urandom, $urandom, $urandom);
    rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("inflight_rst_valid", 32'(bus_a.OUT_valid), 32'd0);
    repeat (5) @(posedge clk);
    #1;

    // random traffic on both instances, one reset pulse midway
    for (int i = 0; i < 600; i++) begin
      rand_drive();
      rst = (i == 300);
      @(posedge clk); #1;
    end
    rst = 1'b0;
    bus_a.IN_valid = 1'b0; bus_b.IN_valid = 1'b0;
    bus_a.OUT_ready = 1'b1; bus_b.OUT_ready = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    chk("drain_a", 32'(qa.size()), 32'd0);
    chk("drain_b", 32'(qb.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
